stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the seconds_counter datapath. Turns one-cycle command
//  pulses into a gated once-per-second enable pulse and a counter clear. Extends the
//  count with a minutes register driven by tick_minute. Sits between button/debounce
//  logic and seconds_counter.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per second; legal range >= 2
//  MIN_W     6            minutes width; minutes wrap 59 -> 0
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  start           in   1      1-cycle pulse: start or resume counting
//  stop            in   1      1-cycle pulse: pause counting
//  clear           in   1      1-cycle pulse: zero all counts, return to IDLE
//  lap             in   1      1-cycle pulse: capture current time
//  seconds_in      in   6      seconds value from seconds_counter
//  tick_minute_in  in   1      seconds_counter 59->0 rollover strobe
//  sec_enable      out  1      enable to seconds_counter: 1-cycle pulse per second
//  cnt_clear       out  1      1-cycle clear pulse; integration drives counter reset with it
//  running         out  1      high in RUNNING state
//  minutes         out  MIN_W  elapsed minutes
//  hour_tick       out  1      1-cycle pulse when minutes wraps 59 -> 0
//  lap_sec/lap_min out  6/MIN_W  captured time (STOPWATCH_LAP_EN only)
//  lap_valid       out  1      captured time held (STOPWATCH_LAP_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE; prescaler=0; sec_enable, cnt_clear, running, hour_tick=0;
//    minutes=0; lap_*=0. rst applied mid-count aborts immediately. Reset has priority
//    over everything else.
//  - FSM states:
//    - IDLE: start -> RUNNING.
//    - RUNNING: stop -> PAUSED; clear -> IDLE.
//    - PAUSED: start -> RUNNING; clear -> IDLE.
//  - Command priority when asserted in the same cycle: clear > stop > start > lap.
//    Commands that do not apply to the current state are ignored.
//  - Prescaler counts 0..TICK_DIV-1 only in RUNNING. sec_enable is registered and
//    high for exactly one cycle, in the cycle after the prescaler reaches TICK_DIV-1.
//  - The first sec_enable after start comes TICK_DIV cycles after the start pulse.
//  - PAUSED: prescaler holds its value, so the partial second is kept on resume.
//  - stop and the terminal count in the same cycle: the pulse is suppressed and the
//    prescaler holds.
//  - clear: cnt_clear high one cycle (next edge); prescaler=0; minutes=0; lap cleared;
//    sec_enable=0. clear is honoured in any state, including IDLE.
//  - tick_minute_in sampled every cycle. minutes+1, wraps 59 -> 0; on the wrap,
//    hour_tick pulses one cycle. tick_minute_in together with clear: clear wins.
//  - running is combinational from the state register (state==RUNNING).
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - lap in RUNNING or PAUSED latches {seconds_in, minutes} into lap_sec/lap_min
//      and sets lap_valid at the next edge.
//    - A later lap overwrites the capture. If lap coincides with tick_minute_in,
//      the pre-increment minutes are captured.
//    - clear/rst drop lap_valid to 0.
//  STOPWATCH_LAP_EN undefined: lap ignored; lap_sec, lap_min, lap_valid tied to 0;
//    no lap registers.
// STRUCTURE
//  - stopwatch_pkg: state typedef (IDLE, RUNNING, PAUSED), MIN_WRAP=59 constant,
//    $clog2-based prescaler width helper.
//  - Sub-module tick_prescaler (inputs clk, rst, run, clr; output tick; param
//    TICK_DIV) holds the divider. FSM, minutes and lap logic live in the top module.
// TESTING (TICK_DIV=4 in bench)
//  1. rst=1 for 3 cycles mid-run -> all outputs 0, state IDLE; start ignored while rst=1.
//  2. start, run 20 cycles -> sec_enable pulses on cycles 4,8,12,16,20 after start,
//     each exactly 1 cycle wide.
//  3. start, stop 2 cycles after a pulse, wait 10, start -> next pulse 2 cycles after
//     resume; no pulse while PAUSED.
//  4. Preload minutes=59 via tick pulses, assert tick_minute_in -> minutes=0,
//     hour_tick one cycle.
//  5. clear+stop+start in the same cycle while RUNNING -> IDLE, cnt_clear one cycle,
//     minutes=0, running=0.
//  6. (LAP_EN) seconds_in=37, minutes=2, lap -> lap_sec=37, lap_min=2, lap_valid=1
//     next edge; clear -> lap_valid=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/clear sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam int MIN_WRAP = 59;

    function automatic int presc_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Once-per-second divider: counts while run is high, holds otherwise.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int W = presc_w(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: FSM, prescaler gating, minutes and optional lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MIN_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    input  logic [5:0]       seconds_in,
    input  logic             tick_minute_in,
    output logic             sec_enable,
    output logic             cnt_clear,
    output logic             running,
    output logic [MIN_W-1:0] minutes,
    output logic             hour_tick,
    output logic [5:0]       lap_sec,
    output logic [MIN_W-1:0] lap_min,
    output logic             lap_valid
);

    state_t           state_q, state_d;
    logic             cnt_clear_q, cnt_clear_d;
    logic [MIN_W-1:0] minutes_q, minutes_d;
    logic             hour_tick_q, hour_tick_d;
    logic             presc_run;

    // A stop or clear in the same cycle must freeze the prescaler at once.
    assign presc_run = (state_q == RUNNING) && !stop && !clear;

    always_comb begin
        state_d     = state_q;
        cnt_clear_d = 1'b0;
        minutes_d   = minutes_q;
        hour_tick_d = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            cnt_clear_d = 1'b1;
            minutes_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUNNING;
                RUNNING: if (stop)  state_d = PAUSED;
                PAUSED:  if (start) state_d = RUNNING;
                default: state_d = IDLE;
            endcase
            if (tick_minute_in) begin
                if (minutes_q == MIN_W'(MIN_WRAP)) begin
                    minutes_d   = '0;
                    hour_tick_d = 1'b1;
                end else begin
                    minutes_d = minutes_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_clear_q <= 1'b0;
            minutes_q   <= '0;
            hour_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_clear_q <= cnt_clear_d;
            minutes_q   <= minutes_d;
            hour_tick_q <= hour_tick_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (presc_run),
        .clr  (clear),
        .tick (sec_enable)
    );

    assign cnt_clear = cnt_clear_q;
    assign running   = (state_q == RUNNING);
    assign minutes   = minutes_q;
    assign hour_tick = hour_tick_q;

`ifdef STOPWATCH_LAP_EN
    logic [5:0]       lap_sec_q, lap_sec_d;
    logic [MIN_W-1:0] lap_min_q, lap_min_d;
    logic             lap_valid_q, lap_valid_d;

    always_comb begin
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_valid_d = lap_valid_q;
        if (clear) begin
            lap_sec_d   = '0;
            lap_min_d   = '0;
            lap_valid_d = 1'b0;
        end else if (lap && (state_q != IDLE)) begin
            lap_sec_d   = seconds_in;
            lap_min_d   = minutes_q;
            lap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
    assign lap_valid = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap = ^{lap, seconds_in};
    assign lap_sec    = '0;
    assign lap_min    = '0;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

    localparam int MIN_W = 6;

    logic             clk = 1'b0;
    logic             rst, start, stop, clear, lap, tick_minute_in;
    logic [5:0]       seconds_in;
    logic             sec_enable, cnt_clear, running, hour_tick, lap_valid;
    logic [MIN_W-1:0] minutes, lap_min;
    logic [5:0]       lap_sec;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .MIN_W    (MIN_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .clear          (clear),
        .lap            (lap),
        .seconds_in     (seconds_in),
        .tick_minute_in (tick_minute_in),
        .sec_enable     (sec_enable),
        .cnt_clear      (cnt_clear),
        .running        (running),
        .minutes        (minutes),
        .hour_tick      (hour_tick),
        .lap_sec        (lap_sec),
        .lap_min        (lap_min),
        .lap_valid      (lap_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        lap = 1'b0; tick_minute_in = 1'b0; seconds_in = 6'd0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_sec_en", {31'd0, sec_enable}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_cnt_clear", {31'd0, cnt_clear}, 32'd0);
        check("rst_minutes", {26'd0, minutes}, 32'd0);
        check("rst_hour_tick", {31'd0, hour_tick}, 32'd0);
        check("rst_lap_valid", {31'd0, lap_valid}, 32'd0);

        // 1: reset mid-run, start held during reset
        start = 1'b1; step(); start = 1'b0;
        tick_minute_in = 1'b1; step(); tick_minute_in = 1'b0;
        step(); step();
        check("t1_pre_running", {31'd0, running}, 32'd1);
        check("t1_pre_minutes", {26'd0, minutes}, 32'd1);
        rst = 1'b1; start = 1'b1; tick_minute_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_rst_running", {31'd0, running}, 32'd0);
            check("t1_rst_sec_en", {31'd0, sec_enable}, 32'd0);
            check("t1_rst_minutes", {26'd0, minutes}, 32'd0);
        end
        rst = 1'b0; start = 1'b0; tick_minute_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t1_idle_running", {31'd0, running}, 32'd0);
            check("t1_idle_sec_en", {31'd0, sec_enable}, 32'd0);
        end

        // 2: pulses at 4,8,12,16,20 after start
        start = 1'b1; step(); start = 1'b0;
        check("t2_running", {31'd0, running}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t2_sec_en_c%0d", k), {31'd0, sec_enable},
                  (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // 3: pause keeps partial second; resume pulses 2 cycles later
        step(); step();
        stop = 1'b1; step(); stop = 1'b0;
        check("t3_paused_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_paused_sec_en", {31'd0, sec_enable}, 32'd0);
        end
        start = 1'b1; step(); start = 1'b0;
        check("t3_resume_running", {31'd0, running}, 32'd1);
        check("t3_resume_c0", {31'd0, sec_enable}, 32'd0);
        step();
        check("t3_resume_c1", {31'd0, sec_enable}, 32'd0);
        step();
        check("t3_resume_c2", {31'd0, sec_enable}, 32'd1);
        step();
        check("t3_resume_c3", {31'd0, sec_enable}, 32'd0);

        // stop on the terminal count suppresses the pulse, prescaler holds
        step(); step();
        stop = 1'b1; step(); stop = 1'b0;
        check("t3b_stop_tc_sec_en", {31'd0, sec_enable}, 32'd0);
        check("t3b_stop_tc_running", {31'd0, running}, 32'd0);
        step(); step();
        check("t3b_hold_sec_en", {31'd0, sec_enable}, 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("t3b_resume_c0", {31'd0, sec_enable}, 32'd0);
        step();
        check("t3b_resume_c1", {31'd0, sec_enable}, 32'd1);

        // 4: minutes wrap 59 -> 0 with hour_tick
        tick_minute_in = 1'b1;
        for (int i = 0; i < 59; i++) step();
        check("t4_min59", {26'd0, minutes}, 32'd59);
        check("t4_no_hour_tick", {31'd0, hour_tick}, 32'd0);
        step();
        tick_minute_in = 1'b0;
        check("t4_wrap_min", {26'd0, minutes}, 32'd0);
        check("t4_hour_tick", {31'd0, hour_tick}, 32'd1);
        step();
        check("t4_hour_tick_off", {31'd0, hour_tick}, 32'd0);
        check("t4_min_hold", {26'd0, minutes}, 32'd0);

        // 5: clear beats stop/start/tick_minute in RUNNING
        tick_minute_in = 1'b1;
        step(); step(); step();
        tick_minute_in = 1'b0;
        check("t5_min3", {26'd0, minutes}, 32'd3);
        check("t5_pre_running", {31'd0, running}, 32'd1);
        clear = 1'b1; stop = 1'b1; start = 1'b1; tick_minute_in = 1'b1;
        step();
        clear = 1'b0; stop = 1'b0; start = 1'b0; tick_minute_in = 1'b0;
        check("t5_running", {31'd0, running}, 32'd0);
        check("t5_cnt_clear", {31'd0, cnt_clear}, 32'd1);
        check("t5_minutes", {26'd0, minutes}, 32'd0);
        check("t5_sec_en", {31'd0, sec_enable}, 32'd0);
        step();
        check("t5_cnt_clear_off", {31'd0, cnt_clear}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_idle_sec_en", {31'd0, sec_enable}, 32'd0);
        end

        // 6: lap capture
        start = 1'b1; step(); start = 1'b0;
        tick_minute_in = 1'b1; step(); step(); tick_minute_in = 1'b0;
        check("t6_min2", {26'd0, minutes}, 32'd2);
        seconds_in = 6'd37; lap = 1'b1; step(); lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
        check("t6_lap_sec", {26'd0, lap_sec}, 32'd37);
        check("t6_lap_min", {26'd0, lap_min}, 32'd2);
        check("t6_lap_valid", {31'd0, lap_valid}, 32'd1);
        seconds_in = 6'd41; lap = 1'b1; tick_minute_in = 1'b1;
        step();
        lap = 1'b0; tick_minute_in = 1'b0;
        check("t6_lap2_sec", {26'd0, lap_sec}, 32'd41);
        check("t6_lap2_min", {26'd0, lap_min}, 32'd2);
        check("t6_lap2_minutes", {26'd0, minutes}, 32'd3);
        clear = 1'b1; step(); clear = 1'b0;
        check("t6_clr_valid", {31'd0, lap_valid}, 32'd0);
        check("t6_clr_sec", {26'd0, lap_sec}, 32'd0);
`else
        check("t6_lap_sec_tied", {26'd0, lap_sec}, 32'd0);
        check("t6_lap_min_tied", {26'd0, lap_min}, 32'd0);
        check("t6_lap_valid_tied", {31'd0, lap_valid}, 32'd0);
        clear = 1'b1; step(); clear = 1'b0;
        check("t6_clr_running", {31'd0, running}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
